// File: rtl/weight_row_packer_pkg.sv
// Shared sizing for the weight path: loader beat width, array geometry, row FIFO depth.
// Loader, packer and array import this so their row layouts agree.
package weight_row_packer_pkg;
    localparam int DATA_W_DEF     = 128;
    localparam int ARRAY_N_DEF    = 32;
    localparam int WT_W_DEF       = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ROW_W_DEF      = ARRAY_N_DEF * WT_W_DEF;
    localparam int WPR_DEF        = ROW_W_DEF / DATA_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } pk_state_e;
endpackage

// File: rtl/weight_row_packer_row_fifo.sv
// First-word-fall-through row FIFO. Extra pointer MSB separates full from empty.
// A push into a full FIFO is only taken when a pop retires an entry the same cycle.
module row_fifo_fwft #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/weight_row_packer.sv
// Packs free-running weight beats into full array rows, buffers them in a FWFT FIFO
// and hands them to the array's weight-load port; pulses tile_done after the last row.
module weight_row_packer
    import weight_row_packer_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int ARRAY_N    = ARRAY_N_DEF,
    parameter  int WT_W       = WT_W_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ROW_W      = ARRAY_N * WT_W,
    localparam int WPR        = ROW_W / DATA_W,
    localparam int RC_W       = $clog2(ARRAY_N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RC_W-1:0]   tile_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              row_valid,
    output logic [ROW_W-1:0]  row_data,
    output logic [RC_W-1:0]   row_idx,
    input  logic              row_ready,
    output logic              busy,
    output logic              tile_done,
    output logic              err_overflow,
    output logic              err_stray
);
    localparam int BC_W = (WPR > 1) ? $clog2(WPR) : 1;

    pk_state_e         state, state_nxt;
    logic [RC_W-1:0]   rows_tgt, rows_in, pop_cnt, tgt_clamped;
    logic [BC_W-1:0]   beat_cnt;
    logic [ROW_W-1:0]  asm_row, row_nxt, fifo_dout;
    logic              fifo_full, fifo_empty, push, pop, last_beat;

    assign tgt_clamped = (tile_rows > RC_W'(ARRAY_N)) ? RC_W'(ARRAY_N) : tile_rows;
    assign last_beat   = (beat_cnt == BC_W'(WPR - 1));
    assign push        = (state == ST_COLLECT) && in_valid && last_beat;
    assign row_valid   = !fifo_empty;
    assign pop         = row_valid && row_ready;
    assign busy        = (state != ST_IDLE);
    assign row_idx     = pop_cnt;
    // Gate the un-reset FIFO storage so row_data reads 0 whenever nothing is presented.
    assign row_data    = fifo_empty ? '0 : fifo_dout;

    always_comb begin
        row_nxt = asm_row;
        row_nxt[int'(beat_cnt)*DATA_W +: DATA_W] = in_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (tgt_clamped == '0) ? ST_DRAIN : ST_COLLECT;
            ST_COLLECT: if (push && (rows_in + RC_W'(1) == rows_tgt)) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rows_tgt     <= '0;
            rows_in      <= '0;
            pop_cnt      <= '0;
            beat_cnt     <= '0;
            asm_row      <= '0;
            err_overflow <= 1'b0;
            err_stray    <= 1'b0;
            tile_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            tile_done <= (state == ST_DRAIN) && fifo_empty;
            if (pop) pop_cnt <= pop_cnt + RC_W'(1);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rows_tgt     <= tgt_clamped;
                        rows_in      <= '0;
                        pop_cnt      <= '0;
                        beat_cnt     <= '0;
                        err_overflow <= 1'b0;
                        err_stray    <= 1'b0;
                    end
                    if (in_valid) err_stray <= 1'b1;
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        asm_row  <= row_nxt;
                        beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
                        // Dropped rows still count so the tile always terminates.
                        if (last_beat) begin
                            rows_in <= rows_in + RC_W'(1);
                            if (fifo_full && !pop) err_overflow <= 1'b1;
                        end
                    end
                end
                default: if (in_valid) err_stray <= 1'b1;
            endcase
        end
    end

    row_fifo_fwft #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (row_nxt),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_weight_row_packer.sv
// Bench for weight_row_packer: queue-level reference model checked every cycle,
// a scenario table, and hand-written sequences for latency, limits and reset.
module tb_weight_row_packer;
    localparam int DATA_W = 128;
    localparam int ARRAY_N = 32;
    localparam int ROW_W = 256;
    localparam int WPR = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, row_ready = 1'b0;
    logic [5:0] tile_rows = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic row_valid, busy, tile_done, err_overflow, err_stray;
    logic [ROW_W-1:0] row_data;
    logic [5:0] row_idx;

    int n_tests = 0, n_fail = 0;
    int pops = 0, dones = 0, last_idx = -1;

    typedef enum {M_IDLE, M_COLL, M_DRAIN} mst_e;
    mst_e m_st;
    int m_tgt, m_in, m_pop;
    logic m_ovf, m_stray, m_done;
    logic [DATA_W-1:0] m_beats[$];
    logic [ROW_W-1:0] m_q[$];

    typedef struct {
        logic [5:0] rows;
        int nbeats;
        int rdy_from;
        int exp_pops;
        logic exp_ovf;
        logic exp_stray;
        int exp_last;
    } scen_t;
    scen_t tbl[5];

    weight_row_packer #(.DATA_W(DATA_W), .ARRAY_N(ARRAY_N), .WT_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tile_rows(tile_rows),
        .in_valid(in_valid), .in_data(in_data), .row_valid(row_valid), .row_data(row_data),
        .row_idx(row_idx), .row_ready(row_ready), .busy(busy), .tile_done(tile_done),
        .err_overflow(err_overflow), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_tgt = 0; m_in = 0; m_pop = 0;
        m_ovf = 0; m_stray = 0; m_done = 0;
        m_beats.delete(); m_q.delete();
    endtask

    task automatic model_step();
        logic do_pop, have_row, accept;
        logic [ROW_W-1:0] r;
        do_pop = (m_q.size() > 0) && row_ready;
        accept = (m_q.size() < DEPTH) || do_pop;
        have_row = 0; m_done = 0; r = '0;
        case (m_st)
            M_IDLE: begin
                if (start) begin
                    m_tgt = (tile_rows > ARRAY_N) ? ARRAY_N : int'(tile_rows);
                    m_in = 0; m_pop = 0; m_ovf = 0; m_stray = 0; m_beats.delete();
                    m_st = (m_tgt == 0) ? M_DRAIN : M_COLL;
                end
                if (in_valid) m_stray = 1;
            end
            M_COLL: if (in_valid) begin
                m_beats.push_back(in_data);
                if (m_beats.size() == WPR) begin
                    foreach (m_beats[k]) r[k*DATA_W +: DATA_W] = m_beats[k];
                    m_beats.delete();
                    have_row = 1;
                    m_in++;
                    if (m_in == m_tgt) m_st = M_DRAIN;
                end
            end
            default: begin
                if (in_valid) m_stray = 1;
                if (m_q.size() == 0) begin m_done = 1; m_st = M_IDLE; end
            end
        endcase
        if (have_row && !accept) m_ovf = 1;
        if (do_pop) begin void'(m_q.pop_front()); m_pop++; end
        if (have_row && accept) m_q.push_back(r);
    endtask

    task automatic check();
        chk("busy", busy, m_st != M_IDLE);
        chk("row_valid", row_valid, m_q.size() > 0);
        chk("tile_done", tile_done, m_done);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_stray", err_stray, m_stray);
        if (m_q.size() > 0) begin
            chk("row_data", row_data, m_q[0]);
            chk("row_idx", row_idx, m_pop);
        end
    endtask

    // Called at a negedge: drive inputs, let one edge pass, step the model, check.
    task automatic cycle(input logic st, input logic [5:0] tr, input logic v,
                         input logic [DATA_W-1:0] d, input logic rdy);
        start = st; tile_rows = tr; in_valid = v; in_data = d; row_ready = rdy;
        #1;
        if (row_valid && row_ready) begin pops++; last_idx = int'(row_idx); end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check();
        if (tile_done) dones++;
    endtask

    function automatic logic [DATA_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && dones == 0; k++) cycle(0, 0, 0, '0, 1);
    endtask

    initial begin
        logic [ROW_W-1:0] e;
        logic [5:0] tr;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {tile_done, err_overflow, err_stray, row_idx}, 0);
        rst_n = 1'b1;

        // Basic tile with latency and packing order checked against constants.
        cycle(1, 2, 0, '0, 1);
        cycle(0, 0, 1, 128'd0, 1);
        chk("basic_no_row_yet", row_valid, 0);
        cycle(0, 0, 1, 128'd1, 1);
        e = {128'd1, 128'd0};
        chk("basic_row0_valid", row_valid, 1);
        chk("basic_row0_data", row_data, e);
        chk("basic_row0_idx", row_idx, 0);
        cycle(0, 0, 1, 128'd2, 1);
        chk("basic_row0_popped", row_valid, 0);
        cycle(0, 0, 1, 128'd3, 1);
        e = {128'd3, 128'd2};
        chk("basic_row1_data", row_data, e);
        chk("basic_row1_idx", row_idx, 1);
        cycle(0, 0, 0, '0, 1);
        chk("basic_busy_before_done", {busy, tile_done}, 2'b10);
        cycle(0, 0, 0, '0, 1);
        chk("basic_done_pulse", {busy, tile_done}, 2'b01);
        cycle(0, 0, 0, '0, 1);
        chk("basic_done_one_cycle", tile_done, 0);

        // Stray beats in IDLE, cleared by the next start; zero-row tile timing.
        cycle(0, 0, 1, rnd_beat(), 0);
        cycle(0, 0, 1, rnd_beat(), 0);
        chk("stray_idle", err_stray, 1);
        cycle(1, 0, 0, '0, 0);
        chk("zero_rows_start", {busy, tile_done, err_stray}, 3'b100);
        cycle(0, 0, 0, '0, 0);
        chk("zero_rows_done", {busy, tile_done}, 2'b01);

        // Scenario table: rows, beats, ready-from-beat, pops, ovf, stray, last idx.
        tbl[0] = '{6'd2, 4, 0, 2, 1'b0, 1'b0, 1};
        tbl[1] = '{6'd4, 8, 8, 4, 1'b0, 1'b0, 3};
        tbl[2] = '{6'd6, 12, 12, 4, 1'b1, 1'b0, 3};
        tbl[3] = '{6'd5, 10, 9, 5, 1'b0, 1'b0, 4};
        tbl[4] = '{6'd40, 80, 0, 32, 1'b0, 1'b1, 31};
        foreach (tbl[i]) begin
            pops = 0; dones = 0; last_idx = -1;
            cycle(1, tbl[i].rows, 0, '0, tbl[i].rdy_from == 0);
            for (int b = 0; b < tbl[i].nbeats; b++) cycle(0, 0, 1, rnd_beat(), b >= tbl[i].rdy_from);
            wait_done(100);
            chk($sformatf("scen%0d_done", i), dones, 1);
            chk($sformatf("scen%0d_pops", i), pops, tbl[i].exp_pops);
            chk($sformatf("scen%0d_last_idx", i), last_idx, tbl[i].exp_last);
            chk($sformatf("scen%0d_ovf", i), err_overflow, tbl[i].exp_ovf);
            chk($sformatf("scen%0d_stray", i), err_stray, tbl[i].exp_stray);
            chk($sformatf("scen%0d_idle", i), busy, 0);
        end

        // Asynchronous reset mid-tile after 3 beats, then a fresh one-row tile.
        cycle(1, 2, 0, '0, 0);
        for (int b = 0; b < 3; b++) cycle(0, 0, 1, rnd_beat(), 0);
        chk("pre_reset_row_valid", row_valid, 1);
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_row", {row_valid, row_data}, 0);
        chk("midrst_ctrl", {busy, tile_done, err_overflow, err_stray, row_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pops = 0; dones = 0;
        cycle(1, 1, 0, '0, 1);
        cycle(0, 0, 1, rnd_beat(), 1);
        cycle(0, 0, 1, rnd_beat(), 1);
        wait_done(20);
        chk("post_reset_done", dones, 1);
        chk("post_reset_pops", pops, 1);

        // Random tiles: gapped beats, random backpressure, full model check each cycle.
        for (int t = 0; t < 12; t++) begin
            dones = 0;
            tr = 6'($urandom_range(0, 40));
            cycle(1, tr, 0, '0, $urandom_range(0, 1));
            for (int k = 0; k < 2000 && dones == 0; k++)
                cycle(0, 0, ($urandom % 4) != 0, rnd_beat(), ($urandom % 3) != 0);
            chk($sformatf("rand%0d_done", t), dones, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
